// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift unit, one bit position per clock.
// Request and result travel over valid/ready handshakes; operands and mode
// bits are captured when the request is accepted.
// Optional feature: define SEQ_SHIFTER_ROTATE_EN to add the rot input, which
// selects rotate instead of shift (AL is then ignored).
module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic             LR,
    input  logic             AL,
`ifdef SEQ_SHIFTER_ROTATE_EN
    input  logic             rot,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [SHW-1:0]   cnt_q,   cnt_d;
    logic             lr_q,    lr_d;
    logic             al_q,    al_d;
`ifdef SEQ_SHIFTER_ROTATE_EN
    logic             rot_q,   rot_d;
`endif

    logic             left_fill;
    logic             right_fill;
    logic [WIDTH-1:0] shift_nxt;

    // Bits shifted in at the vacated end for the captured mode
    always_comb begin
`ifdef SEQ_SHIFTER_ROTATE_EN
        left_fill  = rot_q & shreg_q[WIDTH-1];
        right_fill = rot_q ? shreg_q[0] : (al_q & shreg_q[WIDTH-1]);
`else
        left_fill  = 1'b0;
        right_fill = al_q & shreg_q[WIDTH-1];
`endif
        shift_nxt = lr_q ? {shreg_q[WIDTH-2:0], left_fill}
                         : {right_fill, shreg_q[WIDTH-1:1]};
    end

    // Next-state and datapath update
    // A zero shift amount still passes through one SHIFT cycle (with no shift)
    // so the result appears one cycle after accept, like a shift of one.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        lr_d    = lr_q;
        al_d    = al_q;
`ifdef SEQ_SHIFTER_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = din;
                    cnt_d   = shamt;
                    lr_d    = LR;
                    al_d    = AL;
`ifdef SEQ_SHIFTER_ROTATE_EN
                    rot_d   = rot;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    shreg_d = shift_nxt;
                    cnt_d   = cnt_q - 1'b1;
                end
                if (cnt_q <= SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            lr_q    <= 1'b0;
            al_q    <= 1'b0;
`ifdef SEQ_SHIFTER_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            lr_q    <= lr_d;
            al_q    <= al_d;
`ifdef SEQ_SHIFTER_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        dout      = shreg_q;
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: reset, directed shift cases, back-pressure,
// mid-operation reset, optional rotate cases, and a sweep of corner operands
// against a combinational reference shift.
module tb_seq_shifter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] din;
    logic [2:0] shamt;
    logic       LR;
    logic       AL;
`ifdef SEQ_SHIFTER_ROTATE_EN
    logic       rot;
`endif
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dout;
    logic       busy;

    int checks = 0;
    int errors = 0;

    seq_shifter #(.WIDTH(8), .SHW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .shamt     (shamt),
        .LR        (LR),
        .AL        (AL),
`ifdef SEQ_SHIFTER_ROTATE_EN
        .rot       (rot),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                             input logic lr, input logic al);
        logic signed [7:0] sd;
        sd = d;
        if (lr)      return d << s;
        else if (al) return sd >>> s;
        else         return d >> s;
    endfunction

    // Offer a request once in_ready is seen; returns just after the accept edge
    task automatic accept(input logic [7:0] d, input logic [2:0] s, input logic lr,
                          input logic al, input string tag);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        din = d; shamt = s; LR = lr; AL = al; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait for the result, checking latency from the accept edge and data
    task automatic wait_valid(input int exp_lat, input logic [7:0] exp_dout, input string tag);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_dout"}, 32'(dout), 32'(exp_dout));
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    // Full transaction with operand inputs scrambled while the unit is busy
    task automatic run_op(input logic [7:0] d, input logic [2:0] s, input logic lr,
                          input logic al, input logic [7:0] exp, input string tag);
`ifdef SEQ_SHIFTER_ROTATE_EN
        logic saved_rot = rot;
`endif
        accept(d, s, lr, al, tag);
        din = ~d; shamt = ~s; LR = ~lr; AL = ~al;
`ifdef SEQ_SHIFTER_ROTATE_EN
        rot = ~saved_rot;
`endif
        wait_valid((s == 3'd0) ? 1 : int'(s), exp, tag);
        handshake(tag);
`ifdef SEQ_SHIFTER_ROTATE_EN
        rot = saved_rot;
`endif
    endtask

    logic [7:0] corners [8] = '{8'h00, 8'hFF, 8'h80, 8'h01, 8'hB5, 8'h7F, 8'hAA, 8'h55};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        din = '0; shamt = '0; LR = 1'b0; AL = 1'b0;
`ifdef SEQ_SHIFTER_ROTATE_EN
        rot = 1'b0;
`endif
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed shifts
        run_op(8'hB5, 3'd3, 1'b1, 1'b0, 8'hA8, "left3");
        run_op(8'hB5, 3'd3, 1'b0, 1'b1, 8'hF6, "arith3");
        run_op(8'hB5, 3'd3, 1'b0, 1'b0, 8'h16, "logic3");
        run_op(8'h81, 3'd0, 1'b1, 1'b0, 8'h81, "zero");
        run_op(8'h81, 3'd7, 1'b0, 1'b1, 8'hFF, "arith7");

        // Back-pressure: result held while out_ready low; new request waits
        accept(8'hB5, 3'd3, 1'b1, 1'b0, "bp");
        wait_valid(3, 8'hA8, "bp");
        din = 8'h01; shamt = 3'd1; LR = 1'b1; AL = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_dout", 32'(dout), 32'hA8);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_busy", 32'(busy), 32'd0);
        tick();
        in_valid = 1'b0;
        check("bp_next_accepted", 32'(busy), 32'd1);
        wait_valid(1, 8'h02, "bp_next");
        handshake("bp_next");

        // Reset in the second SHIFT cycle aborts the request
        accept(8'hFF, 3'd7, 1'b0, 1'b0, "abort");
        tick();
        rst = 1'b1;
        tick();
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dout", 32'(dout), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_idle", 32'(in_ready), 32'd1);
        run_op(8'h01, 3'd1, 1'b1, 1'b0, 8'h02, "after_abort");

`ifdef SEQ_SHIFTER_ROTATE_EN
        rot = 1'b1;
        run_op(8'h81, 3'd1, 1'b1, 1'b0, 8'h03, "rotl1");
        run_op(8'h81, 3'd1, 1'b0, 1'b1, 8'hC0, "rotr1");
        run_op(8'hB5, 3'd3, 1'b1, 1'b0, 8'hAD, "rotl3");
        run_op(8'hB5, 3'd3, 1'b0, 1'b1, 8'hB6, "rotr3");
        rot = 1'b0;
`endif

        // Corner sweep against the reference shift
        for (int unsigned i = 0; i < 8; i++) begin
            for (int unsigned s = 0; s < 8; s++) begin
                for (int unsigned lr = 0; lr < 2; lr++) begin
                    for (int unsigned al = 0; al < 2; al++) begin
                        run_op(corners[i], 3'(s), 1'(lr), 1'(al),
                               ref_shift(corners[i], 3'(s), 1'(lr), 1'(al)), "sweep");
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
